phys_reg_free_list: RTL
=======================

// Module: phys_reg_free_list
// PURPOSE
//  Circular FIFO of free physical register tags (phys_reg_tag_t) feeding the rename stage: decode/rename
//  dequeues one tag per renamed dest reg; commit enqueues the displaced old tag it frees. Head pointer is
//  checkpointable so branch-mispredict recovery can restore all tags dequeued after the branch in one cycle.
// PARAMETERS
//  NUM_PHYS_REGS   64  total physical registers (from instr_types_pkg)
//  NUM_ARCH_REGS   32  architectural registers; phys 0..31 hold initial arch mappings
//  DEPTH           NUM_PHYS_REGS-NUM_ARCH_REGS (32)  FIFO entries; power of 2
//  PTR_W           $clog2(DEPTH)+1 (6)  pointer width incl. wrap bit
// PORTS
//  CLK                 in   1      clock, rising edge
//  nRST                in   1      asynchronous active-low reset
//  deq_req             in   1      rename requests a free tag this cycle
//  deq_ack             out  1      = deq_req & ~empty; tag consumed at this edge
//  deq_tag             out  6      tag at head (valid when ~empty)
//  enq_valid           in   1      commit frees a tag this cycle
//  enq_tag             in   6      tag being freed
//  ckpt_head           out  PTR_W  current head pointer, saved by branch checkpoint
//  restore_valid       in   1      mispredict recovery this cycle
//  restore_head        in   PTR_W  head pointer to restore
//  empty               out  1      no free tags
//  full                out  1      all DEPTH entries free
//  count               out  PTR_W  number of free tags (0..DEPTH)
// BEHAVIOUR
//  - Storage: DEPTH x 6b flops; head/tail PTR_W-bit, low bits index, MSB is wrap bit.
//  - Reset (async, nRST=0): entry i = NUM_ARCH_REGS+i (32..63); head=0; tail=DEPTH (wrap bit 1, idx 0);
//    count=32, full=1, empty=0, deq_ack=0, deq_tag=32, ckpt_head=0. Reset mid-operation discards all state.
//  - count = tail - head (PTR_W modular); empty = (head==tail); full = idx equal & wrap bits differ.
//  - deq_tag = entry[head idx], combinational from registered state (0-cycle read).
//  - Dequeue: on edge with deq_ack=1, head <= head+1. deq_req while empty -> deq_ack=0, no change.
//  - Enqueue: on edge with enq_valid=1, entry[tail idx] <= enq_tag, tail <= tail+1. Visible to deq_tag
//    next cycle earliest; no same-cycle bypass (empty + enq_valid + deq_req -> deq_ack=0).
//  - enq_valid while full is illegal (tag leak upstream): write/pointer update suppressed; sim assertion fires.
//  - Restore: restore_valid=1 -> head <= restore_head; same-cycle dequeue ignored (deq_ack forced 0).
//    Same-cycle enqueue still applied (tail advances). restore_head must lie in [tail-DEPTH, tail];
//    entries between restore_head and old head still hold their tags, so no data rewrite needed.
//  - Simultaneous enq+deq (not empty, not full): both apply, count unchanged.
//  - Pointers wrap modulo 2*DEPTH naturally via PTR_W overflow.
//  - No FSM beyond pointer state; single-cycle throughput, 1 deq + 1 enq per cycle.
// TESTING
//  1. Reset, deq_req=1 for 32 cycles -> deq_tag 32,33..63 in order, deq_ack=1 each; then empty=1, deq_ack=0.
//  2. From empty: enq_tag=5 and deq_req same cycle -> deq_ack=0; next cycle deq_tag=5, deq_ack=1.
//  3. Wrap: after 32 deqs + enqs of tags 0..31, 40 further enq/deq pairs -> FIFO order kept, count stable, wrap ok.
//  4. Checkpoint ckpt_head=3 after 3 deqs, 4 more deqs (tags 35..38), restore_valid restore_head=3
//     -> next deq_tag=35, count back to 29; same-cycle deq_req ignored.
//  5. Restore + enq same cycle (enq_tag=7) -> head restored and tail advanced, count = old+4+1.
//  6. Assert nRST mid-stream with partial occupancy -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags for the rename stage.
// The head pointer can be checkpointed and restored in one cycle for mispredict recovery.
module phys_reg_free_list #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  parameter int DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS,
  parameter int PTR_W         = $clog2(DEPTH) + 1,
  parameter int TAG_W         = $clog2(NUM_PHYS_REGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             deq_req_i,
  output logic             deq_ack_o,
  output logic [TAG_W-1:0] deq_tag_o,
  input  logic             enq_valid_i,
  input  logic [TAG_W-1:0] enq_tag_i,
  output logic [PTR_W-1:0] ckpt_head_o,
  input  logic             restore_valid_i,
  input  logic [PTR_W-1:0] restore_head_i,
  output logic             empty_o,
  output logic             full_o,
  output logic [PTR_W-1:0] count_o
);

  localparam int IDX_W = PTR_W - 1;

  logic [TAG_W-1:0] entry_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             enq_ok;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  assign empty_o     = (head_q == tail_q);
  assign full_o      = (head_idx == tail_idx) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);
  assign count_o     = tail_q - head_q;
  assign ckpt_head_o = head_q;
  assign deq_tag_o   = entry_q[head_idx];

  // A restore owns the head this cycle, so any dequeue is refused rather than lost.
  assign deq_ack_o = deq_req_i & ~empty_o & ~restore_valid_i;
  assign enq_ok    = enq_valid_i & ~full_o;

  always_comb begin
    head_d = head_q;
    if (restore_valid_i) begin
      head_d = restore_head_i;
    end else if (deq_ack_o) begin
      head_d = head_q + PTR_W'(1);
    end
  end

  always_comb begin
    tail_d = tail_q;
    if (enq_ok) begin
      tail_d = tail_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= PTR_W'(DEPTH);
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Every non-architectural register starts out free, in ascending order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= TAG_W'(NUM_ARCH_REGS + i);
      end
    end else if (enq_ok) begin
      entry_q[tail_idx] <= enq_tag_i;
    end
  end

  // Freeing a tag into a full list means a tag was duplicated upstream.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(enq_valid_i && full_o));

endmodule
